// File: rtl/id_exe_skid_buffer.sv
// rtl/id_exe_skid_buffer.sv - two-entry registered skid buffer between ID and EXE
module id_exe_skid_buffer #(
  parameter int DATA_W = 150
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

  // Occupancy doubles as the FSM state so count is a direct register output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and entry movement; flush overrides any transfer this cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            main_d  = '0;
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end

    // Handshake flags come from the next count so both stay pure flop outputs.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State registers with asynchronous clear of both entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_q;

endmodule

// File: doc/id_exe_skid_buffer.md
# id_exe_skid_buffer

Two-entry elastic buffer at the EXE end of the ID/EXE boundary. It receives the decoded instruction bundle from the ID pipeline register through a valid/ready handshake and presents it to the EXE stage. The EXE stage can stall on multi-cycle operations, such as SRAM waits, and no bundle is lost or duplicated. All outputs are registered: `in_ready` has no combinational path from `out_ready`, which breaks the backpressure timing path into ID.

## Interface
- `DATA_W`, default 150, width of the packed bundle. Field layout, MSB to LSB:
  - [149] WB_EN, [148] MEM_R_EN, [147] MEM_W_EN, [146] B, [145] S
  - [144:141] EXE_CMD, [140:109] PC, [108:77] Val_Rn, [76:45] Val_Rm, [44] imm
  - [43:32] Shift_operand, [31:8] Signed_imm_24, [7:4] Dest, [3:0] SR
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `flush` input, 1: synchronous pipeline flush (branch taken).
- `in_valid` input, 1: ID offers a bundle.
- `in_data` input, DATA_W: bundle from ID.
- `in_ready` output, 1: registered; buffer can accept a bundle this cycle.
- `out_valid` output, 1: registered; EXE has a bundle this cycle.
- `out_data` output, DATA_W: registered; bundle to EXE.
- `out_ready` input, 1: EXE consumes the bundle this cycle.
- `count` output, 2: registered occupancy, 0..2.

## Operation
**Storage**
- Two entries: MAIN (drives `out_data`) and SKID.
- in_fire = `in_valid` & `in_ready`; out_fire = `out_valid` & `out_ready`.

**State machine on `count`**
- EMPTY (0)
  - in_fire: MAIN←`in_data`, go to ONE.
- ONE (1)
  - in_fire & out_fire: MAIN←`in_data`, stay in ONE.
  - in_fire only: SKID←`in_data`, go to FULL.
  - out_fire only: MAIN←0, go to EMPTY.
  - Neither: hold.
- FULL (2)
  - `in_ready`=0, so in_fire is impossible.
  - out_fire: MAIN←SKID, SKID←0, go to ONE.
  - No out_fire: hold.

**Derived outputs**
- `out_valid` = (`count` != 0).
- `in_ready` = (`count` != 2), held in its own register and updated from the next-state count.

**Flush**
- Takes priority over every transfer in the same cycle.
- Next state: MAIN=0, SKID=0, `count`=0, `out_valid`=0, `in_ready`=1.
- An `in_valid` bundle present in the flush cycle is dropped.
- An `out_fire` in the flush cycle still counts as consumed by EXE; the buffer does not re-present it.

**Bubble rule:** `out_data` is all zeros whenever `out_valid`=0. A zero bundle is a NOP: WB_EN, MEM_R_EN, MEM_W_EN, B and S are all 0.

**Data handling:** data is passed through bit-exact, with no arithmetic and no reordering. Order is FIFO.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1, SKID=0.
- Reset mid-operation discards both entries immediately (asynchronous). The first in_fire is allowed on the first rising edge after `rst` deasserts.
- Latency: in_fire at edge N gives `out_valid`=1 with that bundle in cycle N+1, when the buffer was EMPTY.
- Throughput: 1 bundle/cycle sustained while `out_ready`=1.
- Backpressure:
  - If `out_ready` drops while `in_valid`=1, exactly one further bundle is absorbed into SKID.
  - `in_ready` falls one cycle later.
  - When `out_ready` returns, `in_ready` rises the cycle after the first out_fire.
- `in_data` is sampled only on in_fire.
- The sender must hold `in_valid` and `in_data` stable until in_fire; the buffer does not check this.
- `out_data` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
- The buffer never drops, duplicates or reorders a bundle, except on flush.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with `count`=2. Required: `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1 with no clock edge. After release, bundle A (PC=0x4, Dest=3) with `out_ready`=1 appears on `out_data` one cycle later.
- **Streaming:** `in_valid`=1 and `out_ready`=1 for 8 bundles, PC=0x0,0x4..0x1C. Required: outputs in order, one per cycle, `count` stays 1, `in_ready` always 1.
- **Stall and resume:**
  - Send A, B, C back-to-back with `out_ready`=0 from cycle 1. Required: A in MAIN, B in SKID, `count`=2, `in_ready`=0; C is held by the sender.
  - Raise `out_ready`. Required: A, B, C emerge in consecutive cycles after a single refill bubble at most, with no loss.
- **Flush with full buffer:** flush at `count`=2 with `in_valid`=1 (bundle D). Required: next cycle `count`=0, `out_valid`=0, `out_data`=0, `in_ready`=1; D is never output.
- **Simultaneous fire at ONE:** in_fire and out_fire in the same cycle. Required: `count` stays 1 and the new bundle is on `out_data` next cycle.
- **Bubble check:** drain to EMPTY. Required: `out_data`=150'h0 while `out_valid`=0, and the field layout round-trips an all-ones bundle exactly.
